// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and counter width helpers for the MAC sequencer
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MUL    = 2'd1,
      ACC_LO = 2'd2,
      ACC_HI = 2'd3
   } mac_state_t;

   // Step counter must hold values up to N-1 with one bit of headroom.
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/mac_seq_ctrl_adder.sv
// rtl/mac_seq_ctrl_adder.sv - N-bit ripple-carry adder shared by the MAC sequencer
module Adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);

   logic [N:0] c;

   assign c[0] = ci;

   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
   end

   assign co = c[N];

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequential multiply-accumulate controller time-sharing one ripple adder
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           clear,
   input  logic [N-1:0]   x,
   input  logic [N-1:0]   y,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] acc,
   output logic           ovf
);

   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   mac_state_t      state;
   logic [N-1:0]    xr;
   logic [2*N-1:0]  p;
   logic [CW-1:0]   cnt;
   logic            cs;

   logic [N-1:0]    add_a;
   logic [N-1:0]    add_b;
   logic            add_ci;
   logic [N-1:0]    add_s;
   logic            add_co;

   // Route the single adder to the multiplier partial sum or one accumulator half.
   always_comb begin
      add_a  = '0;
      add_b  = '0;
      add_ci = 1'b0;
      case (state)
         MUL: begin
            add_a = p[2*N-1:N];
            add_b = p[0] ? xr : '0;
         end
         ACC_LO: begin
            add_a = acc[N-1:0];
            add_b = p[N-1:0];
         end
         ACC_HI: begin
            add_a  = acc[2*N-1:N];
            add_b  = p[2*N-1:N];
            add_ci = cs;
         end
         default: begin
            add_a  = '0;
            add_b  = '0;
            add_ci = 1'b0;
         end
      endcase
   end

   Adder #(.N(N)) u_adder (
      .a  (add_a),
      .b  (add_b),
      .ci (add_ci),
      .s  (add_s),
      .co (add_co)
   );

   // Sequencer: latch operands, run N shift-add steps, then add product into acc in two halves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         xr    <= '0;
         p     <= '0;
         cnt   <= '0;
         cs    <= 1'b0;
         acc   <= '0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Clear and start on the same edge: the new product lands in an empty acc.
               if (clear) begin
                  acc <= '0;
                  ovf <= 1'b0;
               end
               if (start) begin
                  xr    <= x;
                  p     <= {{N{1'b0}}, y};
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= MUL;
               end
            end
            MUL: begin
               // {co, sum, lo} shifted right by one keeps the product 2N bits wide.
               p   <= {add_co, add_s, p[N-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  state <= ACC_LO;
               end
            end
            ACC_LO: begin
               acc[N-1:0] <= add_s;
               cs         <= add_co;
               state      <= ACC_HI;
            end
            ACC_HI: begin
               acc[2*N-1:N] <= add_s;
               if (add_co) begin
                  ovf <= 1'b1;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - table-driven self-checking bench for mac_seq_ctrl
module tb_mac_seq_ctrl;

   localparam int N = 8;

   logic           clk;
   logic           rst;
   logic           start;
   logic           clear;
   logic [N-1:0]   x;
   logic [N-1:0]   y;
   logic           busy;
   logic           done;
   logic [2*N-1:0] acc;
   logic           ovf;

   int n_chk;
   int n_fail;
   int done_cnt;
   logic busy_err;

   typedef struct {
      logic [7:0]  vx;
      logic [7:0]  vy;
      logic        clr;
      int          inj;
      logic [15:0] exp_acc;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[8];

   mac_seq_ctrl #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .clear (clear),
      .x     (x),
      .y     (y),
      .busy  (busy),
      .done  (done),
      .acc   (acc),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the done cycle (or on timeout).
   task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input logic clr,
                         input int inj, output int lat);
      start = 1'b1; clear = clr; x = xa; y = ya;
      busy_err = 1'b0;
      @(negedge clk);
      start = 1'b0; clear = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) busy_err = 1'b1;
         if (lat == inj) begin
            start = 1'b1; clear = 1'b1; x = 8'd9; y = 8'd9;
         end else if (lat == inj + 1) begin
            start = 1'b0; clear = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0; clear = 1'b0;
   endtask

   initial begin
      int lat;
      int d0;
      n_chk = 0; n_fail = 0; done_cnt = 0; busy_err = 1'b0;
      rst = 1'b0; start = 1'b0; clear = 1'b0; x = '0; y = '0;

      vecs[0] = '{8'd3,   8'd5,   1'b1, 0, 16'd15,    1'b0};
      vecs[1] = '{8'd12,  8'd10,  1'b1, 0, 16'd120,   1'b0};
      vecs[2] = '{8'd200, 8'd3,   1'b0, 0, 16'd720,   1'b0};
      vecs[3] = '{8'd255, 8'd255, 1'b1, 0, 16'd65025, 1'b0};
      vecs[4] = '{8'd255, 8'd255, 1'b0, 0, 16'd64514, 1'b1};
      vecs[5] = '{8'd1,   8'd1,   1'b0, 0, 16'd64515, 1'b1};
      vecs[6] = '{8'd2,   8'd7,   1'b0, 4, 16'd64529, 1'b1};
      vecs[7] = '{8'd9,   8'd0,   1'b0, 0, 16'd64529, 1'b1};

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      check("reset_acc",  acc,  0);
      check("reset_ovf",  ovf,  0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         d0 = done_cnt;
         run_op(vecs[i].vx, vecs[i].vy, vecs[i].clr, vecs[i].inj, lat);
         check($sformatf("v%0d_latency", i), lat, 11);
         check($sformatf("v%0d_busy_during", i), busy_err, 0);
         check($sformatf("v%0d_busy_at_done", i), busy, 0);
         check($sformatf("v%0d_acc", i), acc, vecs[i].exp_acc);
         check($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_ovf);
         @(negedge clk);
         check($sformatf("v%0d_done_one_cycle", i), done, 0);
         if (vecs[i].inj != 0) begin
            repeat (14) @(negedge clk);
            check($sformatf("v%0d_single_done", i), done_cnt, d0 + 1);
            check($sformatf("v%0d_no_second_op", i), busy, 0);
            check($sformatf("v%0d_acc_hold", i), acc, vecs[i].exp_acc);
         end
      end

      // Reset in cycle 5 of MUL aborts the operation
      d0 = done_cnt;
      start = 1'b1; x = 8'd3; y = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      check("midrst_acc",  acc,  0);
      check("midrst_ovf",  ovf,  0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("midrst_no_done", done_cnt, d0);
      check("midrst_idle", busy, 0);

      run_op(8'd4, 8'd4, 1'b0, 0, lat);
      check("after_rst_latency", lat, 11);
      check("after_rst_acc", acc, 16);
      @(negedge clk);

      // Clear alone in IDLE
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_acc", acc, 0);
      check("clear_ovf", ovf, 0);

      // Back-to-back: second start issued in the done cycle
      run_op(8'd5, 8'd6, 1'b1, 0, lat);
      check("b2b_first_latency", lat, 11);
      check("b2b_first_acc", acc, 30);
      run_op(8'd7, 8'd8, 1'b0, 0, lat);
      check("b2b_second_latency", lat, 11);
      check("b2b_second_acc", acc, 86);
      check("b2b_ovf", ovf, 0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequential multiply-accumulate controller built around a single shared N-bit ripple `Adder`. It time-multiplexes that adder between two jobs: shift-and-add multiplication of two unsigned operands, and a two-pass (low half, then high half) addition of the 2N-bit product into a 2N-bit accumulator. It is the top-level MAC datapath sequencer; the host starts one operation at a time with a start/busy/done handshake.

## Interface
- `N`, default 8: operand width. The accumulator and the product are 2N bits wide.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a MAC operation. Sampled only in IDLE.
- `clear`, input, 1: synchronous clear of `acc` and `ovf`. Honoured only in IDLE.
- `x`, input, N: multiplicand, unsigned. Sampled with `start`.
- `y`, input, N: multiplier, unsigned. Sampled with `start`.
- `busy`, output, 1: high while an operation is in progress.
- `done`, output, 1: registered one-cycle pulse when `acc` has been updated.
- `acc`, output, 2N: accumulator, registered.
- `ovf`, output, 1: sticky flag, set on a carry-out from the accumulator's high half.

## Operation
- States:
  - IDLE: waits for `start`.
  - MUL: N cycles of shift-add.
  - ACC_LO: adds the low half of the product into the accumulator.
  - ACC_HI: adds the high half, using the carry saved from ACC_LO.
- Registers:
  - `xr` [N]: latched multiplicand.
  - `P` [2N]: product, as {hi, lo}.
  - `cnt`: log2(N)+1 bits.
  - `cs`: 1 bit, the saved low-half carry.
  - `acc`, `ovf`.
- IDLE with `start` = 1:
  - `xr` <= x; `P` <= {0, y}; `cnt` <= 0; go to MUL.
  - If `clear` is also 1, `acc` and `ovf` clear on the same edge, so this operation yields `acc` = x*y.
- IDLE with `start` = 0 and `clear` = 1: `acc` <= 0, `ovf` <= 0.
- Adder input mux, with one adder instance only:
  - MUL: a = P.hi, b = P[0] ? xr : 0, ci = 0. Then P <= {co, s, P.lo} >> 1 and `cnt`++. After the Nth step, go to ACC_LO.
  - ACC_LO: a = acc.lo, b = P.lo, ci = 0. acc.lo <= s; cs <= co. Go to ACC_HI.
  - ACC_HI: a = acc.hi, b = P.hi, ci = cs. acc.hi <= s; if co = 1, `ovf` <= 1. `done` <= 1. Go to IDLE.
- Arithmetic: `acc` wraps modulo 2^(2N). `ovf` stays set until `clear` or `rst`.
- `start` or `clear` while busy: ignored, not queued. Operand changes while busy have no effect.
- `busy` = 1 in MUL, ACC_LO and ACC_HI, and 0 in IDLE.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - `acc` = 0, `ovf` = 0, `busy` = 0, `done` = 0.
  - `P`, `xr`, `cnt` and `cs` = 0.
- Reset mid-operation aborts the operation. There is no partial update and no `done`.
- Let the `start` cycle be cycle 0:
  - MUL occupies cycles 1..N.
  - ACC_LO is cycle N+1.
  - ACC_HI is cycle N+2.
  - `done` = 1 and `busy` = 0 in cycle N+3, with the new `acc` valid.
- A new `start` is accepted in cycle N+3, the same cycle as `done`. Throughput is one MAC per N+3 cycles.
- `done` is high for exactly one cycle per operation.
- `acc` changes only at the ACC_LO and ACC_HI edges, or on a clear. The low half is visible updated during cycle N+2; consumers use `acc` only when `done` = 1 or `busy` = 0.

## Structure
- Shared package `mac_pkg` holds:
  - the state encoding: IDLE = 0, MUL = 1, ACC_LO = 2, ACC_HI = 3, on 2 bits;
  - width helpers for the counter.
- One sub-module: the existing `Adder #(N)` ripple adder, instantiated exactly once. The block contains no other `+` operator on N-bit data.
- The counter increment may be a behavioural `+`.

## Test plan
All scenarios use N = 8.
- Reset: assert `rst` asynchronously mid-cycle. Required: `acc` = 0, `ovf` = 0, `busy` = 0 and `done` = 0 immediately.
- Basic operation: `clear` + `start` with x = 3, y = 5. Required: `busy` in cycles 1–10, `done` in cycle 11, `acc` = 15, `ovf` = 0.
- Accumulate and overflow:
  - x = 255, y = 255 gives `acc` = 65025.
  - Repeating it gives `acc` = 64514 and `ovf` = 1.
  - Then x = 1, y = 1 gives `acc` = 64515 with `ovf` still 1.
  - `clear` then returns `acc` = 0, `ovf` = 0.
- Ignored inputs: pulse `start` (x = 9, y = 9) and `clear` in cycle 4 of an operation with x = 2, y = 7. Required: a single `done`, `acc` = previous + 14, no second operation.
- Reset mid-operation: assert `rst` in cycle 5 of MUL. Required: IDLE, `acc` = 0, no `done`. A following x = 4, y = 4 gives `acc` = 16.
- Zero operands and back-to-back: y = 0 leaves `acc` unchanged (`done` still pulses). `start` asserted in the `done` cycle is accepted, and the next `done` follows 11 cycles later.
